// File: rtl/xcorr_pkg.sv
// Shared types and elaboration helpers for the cross-correlation lag search.
package xcorr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int term_bits(input int buf_depth, input int max_lag);
      return $clog2(buf_depth - 2*max_lag);
   endfunction

   // Accumulator must absorb N full-width products; lag field must hold +/-max_lag.
   function automatic bit widths_ok(input int acc_w, input int data_w, input int lag_w,
                                    input int addr_w, input int buf_depth, input int max_lag);
      return (acc_w >= 2*data_w + term_bits(buf_depth, max_lag)) &&
             (max_lag <= (2**(lag_w-1)) - 1) &&
             ((2**addr_w) >= buf_depth) &&
             (2*max_lag < buf_depth);
   endfunction

endpackage

// File: rtl/xcorr_mac.sv
// Tagged multiply-accumulate: tags are delayed to line up with buffer data,
// then product register, then accumulator that restarts on a first tag.
module xcorr_mac
   import xcorr_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int ACC_W  = 41,
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_vld,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic signed [DATA_W-1:0] data_a,
   input  logic signed [DATA_W-1:0] data_b,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     sum_valid
);

   logic [2:0] tag_d;

   generate
      if (RD_LAT == 0) begin : g_lat0
         assign tag_d = {in_vld, in_first, in_last};
      end else begin : g_lat
         logic [2:0] tag_pipe [RD_LAT];
         always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
               for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
            end else begin
               tag_pipe[0] <= {in_vld, in_first, in_last};
               for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            end
         end
         assign tag_d = tag_pipe[RD_LAT-1];
      end
   endgenerate

   // product stage
   logic signed [2*DATA_W-1:0] prod_p1;
   logic                       vld_p1, first_p1, last_p1;

   always_ff @(posedge clk) begin
      prod_p1 <= data_a * data_b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
      end else begin
         vld_p1   <= tag_d[2];
         first_p1 <= tag_d[1];
         last_p1  <= tag_d[0];
      end
   end

   // accumulate stage
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_p2;
   logic                    vld_p2;

   assign prod_ext = ACC_W'(prod_p1);

   always_ff @(posedge clk) begin
      if (vld_p1) acc_p2 <= first_p1 ? prod_ext : acc_p2 + prod_ext;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) vld_p2 <= 1'b0;
      else                 vld_p2 <= vld_p1 & last_p1;
   end

   assign sum       = acc_p2;
   assign sum_valid = vld_p2;

endmodule

// File: rtl/xcorr_lag_search.sv
// Lag search over frozen A/B buffers: sequences n (inner) and L (outer),
// accumulates S(L) in xcorr_mac and keeps the first-seen strict peak.
module xcorr_lag_search
   import xcorr_pkg::*;
#(
   parameter int BUF_DEPTH = 500,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 12,
   parameter int MAX_LAG   = 13,
   parameter int LAG_W     = 5,
   parameter int ACC_W     = 41,
   parameter int RD_LAT    = 1,
   parameter int PEAK_ABS  = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     full,
   output logic [ADDR_W-1:0]        rd_addr_a,
   output logic [ADDR_W-1:0]        rd_addr_b,
   input  logic signed [DATA_W-1:0] data_a,
   input  logic signed [DATA_W-1:0] data_b,
   output logic                     busy,
   output logic                     ready,
   output logic                     result_valid,
   output logic signed [LAG_W-1:0]  best_lag,
   output logic signed [ACC_W-1:0]  best_peak
);

   generate
      if (!widths_ok(ACC_W, DATA_W, LAG_W, ADDR_W, BUF_DEPTH, MAX_LAG)) begin : g_bad_widths
         $error("xcorr_lag_search: parameter widths cannot hold the correlation range");
      end
   endgenerate

   localparam logic [ADDR_W-1:0]       N_FIRST  = ADDR_W'(MAX_LAG);
   localparam logic [ADDR_W-1:0]       N_LAST   = ADDR_W'(BUF_DEPTH - MAX_LAG - 1);
   localparam logic [ADDR_W-1:0]       LAG_LAST = ADDR_W'(2*MAX_LAG);
   localparam logic signed [LAG_W-1:0] LAG_MIN  = LAG_W'(-MAX_LAG);
   localparam logic signed [LAG_W-1:0] LAG_MAX  = LAG_W'(MAX_LAG);

   function automatic logic signed [ACC_W:0] mag(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W:0] w;
      w = (ACC_W+1)'(v);
      return (w < 0) ? -w : w;
   endfunction

   function automatic logic better(input logic signed [ACC_W-1:0] cand,
                                   input logic signed [ACC_W-1:0] cur);
      if (PEAK_ABS != 0) return mag(cand) > mag(cur);
      return cand > cur;
   endfunction

   state_t                  state;
   logic [ADDR_W-1:0]       n_cnt, b_cnt, b_base, lag_idx;
   logic                    iss_vld, iss_first, iss_last;
   logic signed [ACC_W-1:0] sum, run_peak;
   logic                    sum_valid;
   logic signed [LAG_W-1:0] cmp_lag, run_lag;
   logic                    active, abort, take;

   assign active = (state == RUN) || (state == DRAIN);
   assign abort  = active && !full;
   // The most negative lag seeds the peak; later lags must strictly beat it.
   assign take   = (cmp_lag == LAG_MIN) || better(sum, run_peak);

   xcorr_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .RD_LAT(RD_LAT)) u_mac (
      .clk(clk), .rst_n(rst_n), .flush(abort),
      .in_vld(iss_vld), .in_first(iss_first), .in_last(iss_last),
      .data_a(data_a), .data_b(data_b),
      .sum(sum), .sum_valid(sum_valid)
   );

   always_ff @(posedge clk) begin
      if (sum_valid && active && full && take) begin
         run_lag  <= cmp_lag;
         run_peak <= sum;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         rd_addr_a <= '0;  rd_addr_b <= '0;
         n_cnt <= N_FIRST; b_cnt <= '0; b_base <= '0; lag_idx <= '0;
         iss_vld <= 1'b0;  iss_first <= 1'b0; iss_last <= 1'b0;
         busy <= 1'b0;     ready <= 1'b0;     result_valid <= 1'b0;
         best_lag <= '0;   best_peak <= '0;   cmp_lag <= LAG_MIN;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: if (full) begin
               state <= RUN;  busy <= 1'b1; ready <= 1'b0;
               n_cnt <= N_FIRST; b_cnt <= '0; b_base <= '0; lag_idx <= '0;
               cmp_lag <= LAG_MIN;
            end
            RUN: if (!full) begin
               state <= IDLE; busy <= 1'b0; iss_vld <= 1'b0;
            end else begin
               rd_addr_a <= n_cnt;
               rd_addr_b <= b_cnt;
               iss_vld   <= 1'b1;
               iss_first <= (n_cnt == N_FIRST);
               iss_last  <= (n_cnt == N_LAST);
               // b restarts at MAX_LAG+L for each new lag, i.e. one past the previous base
               if (n_cnt == N_LAST) begin
                  n_cnt   <= N_FIRST;
                  b_base  <= b_base + 1'b1;
                  b_cnt   <= b_base + 1'b1;
                  lag_idx <= lag_idx + 1'b1;
                  if (lag_idx == LAG_LAST) state <= DRAIN;
               end else begin
                  n_cnt <= n_cnt + 1'b1;
                  b_cnt <= b_cnt + 1'b1;
               end
            end
            DRAIN: begin
               iss_vld <= 1'b0;
               if (!full) begin
                  state <= IDLE; busy <= 1'b0;
               end else if (sum_valid && cmp_lag == LAG_MAX) begin
                  state <= DONE; busy <= 1'b0; ready <= 1'b1; result_valid <= 1'b1;
                  best_lag  <= take ? cmp_lag : run_lag;
                  best_peak <= take ? sum : run_peak;
               end
            end
            DONE: if (!full) begin
               state <= IDLE; ready <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (active && full && sum_valid) cmp_lag <= cmp_lag + 1'b1;
      end
   end

endmodule

// File: tb/tb_xcorr_lag_search.sv
// Bench for xcorr_lag_search: three instances (RD_LAT=1, RD_LAT=2, |S| peak)
// on small buffers, checked against a direct sum-of-products model.
module tb_xcorr_lag_search;

   localparam int BD = 16, ML = 2, AW = 4, DW = 12, LW = 5, AC = 41;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic full0, full1, full2;
   logic signed [DW-1:0] mem_a [BD];
   logic signed [DW-1:0] mem_b [BD];

   logic [AW-1:0]        ra0, rb0, ra1, rb1, ra2, rb2;
   logic signed [DW-1:0] da0, db0, da1, db1, da1_s, db1_s, da2, db2;
   logic                 busy0, ready0, rv0, busy1, ready1, rv1, busy2, ready2, rv2;
   logic signed [LW-1:0] bl0, bl1, bl2;
   logic signed [AC-1:0] bp0, bp1, bp2;

   // buffer read models: one-cycle (inst 0, 2) and two-cycle (inst 1) latency
   always @(posedge clk) begin
      da0 <= mem_a[ra0];   db0 <= mem_b[rb0];
      da1_s <= mem_a[ra1]; db1_s <= mem_b[rb1];
      da1 <= da1_s;        db1 <= db1_s;
      da2 <= mem_a[ra2];   db2 <= mem_b[rb2];
   end

   xcorr_lag_search #(.BUF_DEPTH(BD), .ADDR_W(AW), .DATA_W(DW), .MAX_LAG(ML), .LAG_W(LW),
                      .ACC_W(AC), .RD_LAT(1), .PEAK_ABS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .full(full0), .rd_addr_a(ra0), .rd_addr_b(rb0),
      .data_a(da0), .data_b(db0), .busy(busy0), .ready(ready0), .result_valid(rv0),
      .best_lag(bl0), .best_peak(bp0));

   xcorr_lag_search #(.BUF_DEPTH(BD), .ADDR_W(AW), .DATA_W(DW), .MAX_LAG(ML), .LAG_W(LW),
                      .ACC_W(AC), .RD_LAT(2), .PEAK_ABS(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .full(full1), .rd_addr_a(ra1), .rd_addr_b(rb1),
      .data_a(da1), .data_b(db1), .busy(busy1), .ready(ready1), .result_valid(rv1),
      .best_lag(bl1), .best_peak(bp1));

   xcorr_lag_search #(.BUF_DEPTH(BD), .ADDR_W(AW), .DATA_W(DW), .MAX_LAG(ML), .LAG_W(LW),
                      .ACC_W(AC), .RD_LAT(1), .PEAK_ABS(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .full(full2), .rd_addr_a(ra2), .rd_addr_b(rb2),
      .data_a(da2), .data_b(db2), .busy(busy2), .ready(ready2), .result_valid(rv2),
      .best_lag(bl2), .best_peak(bp2));

   int errors = 0;
   int checks = 0;

   function automatic logic get_busy(input int w);
      case (w) 0: return busy0; 1: return busy1; default: return busy2; endcase
   endfunction
   function automatic logic get_ready(input int w);
      case (w) 0: return ready0; 1: return ready1; default: return ready2; endcase
   endfunction
   function automatic logic get_rv(input int w);
      case (w) 0: return rv0; 1: return rv1; default: return rv2; endcase
   endfunction
   function automatic int get_lag(input int w);
      case (w) 0: return int'(bl0); 1: return int'(bl1); default: return int'(bl2); endcase
   endfunction
   function automatic longint get_peak(input int w);
      case (w) 0: return longint'(bp0); 1: return longint'(bp1); default: return longint'(bp2); endcase
   endfunction

   task automatic set_full(input int w, input logic v);
      case (w) 0: full0 = v; 1: full1 = v; default: full2 = v; endcase
   endtask

   function automatic longint absl(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference: S(L) straight from the definition, first strict maximum wins.
   function automatic void model(input bit abs_mode, output int lag, output longint peak);
      longint s, best;
      int bl;
      best = 0; bl = 0;
      for (int L = -ML; L <= ML; L++) begin
         s = 0;
         for (int n = ML; n <= BD-ML-1; n++) s += longint'(mem_a[n]) * longint'(mem_b[n+L]);
         if (L == -ML || (abs_mode ? (absl(s) > absl(best)) : (s > best))) begin
            best = s; bl = L;
         end
      end
      lag = bl; peak = best;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < BD; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
   endtask

   // Raise full, count edges to ready (lat = edges after the accepting edge), then drop full.
   task automatic run_frame(input int w, output int lat, output int rv_cnt,
                            output bit rv_rise, output bit busy_seen);
      lat = -1; rv_cnt = 0; rv_rise = 0; busy_seen = 0;
      @(negedge clk); set_full(w, 1'b1);
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (c == 1) busy_seen = get_busy(w);
         if (get_rv(w)) rv_cnt++;
         if (get_ready(w)) begin lat = c - 1; rv_rise = get_rv(w); break; end
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (get_rv(w)) rv_cnt++;
      end
      @(negedge clk); set_full(w, 1'b0);
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; full0 = 1'b0; full1 = 1'b0; full2 = 1'b0;
      clear_mem();
      repeat (3) @(posedge clk); #1;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
      checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready0); end
      checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", rv0); end
      checks++; if (bl0 !== '0) begin errors++; $display("FAIL reset_lag: got %0d want 0", bl0); end
      checks++; if (bp0 !== '0) begin errors++; $display("FAIL reset_peak: got %0d want 0", bp0); end
      checks++; if (ra0 !== '0 || rb0 !== '0) begin errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", ra0, rb0); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   // Full frame on instance w: latency, strobe behaviour, and result vs the model.
   task automatic check_frame(input string name, input int w, input int exp_lat);
      int lat, rvc, elag;
      bit rise, bsy;
      longint epk;
      model(w == 2, elag, epk);
      run_frame(w, lat, rvc, rise, bsy);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
      checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, bsy); end
      checks++; if (rvc !== 1 || rise !== 1'b1) begin errors++; $display("FAIL %s_strobe: got count %0d at_rise %b want 1/1", name, rvc, rise); end
      checks++; if (get_lag(w) !== elag) begin errors++; $display("FAIL %s_lag: got %0d want %0d", name, get_lag(w), elag); end
      checks++; if (get_peak(w) !== epk) begin errors++; $display("FAIL %s_peak: got %0d want %0d", name, get_peak(w), epk); end
      checks++; if (get_ready(w) !== 1'b0) begin errors++; $display("FAIL %s_ready_fall: got %b want 0", name, get_ready(w)); end
   endtask

   task automatic test_delay_plus1();
      clear_mem(); mem_a[8] = 100; mem_b[9] = 50;
      check_frame("delay", 0, 64);
      checks++; if (bl0 !== 5'sd1 || bp0 !== 41'sd5000) begin errors++; $display("FAIL delay_const: got %0d/%0d want 1/5000", bl0, bp0); end
   endtask

   task automatic test_edge_lag_rdlat2();
      clear_mem(); mem_a[8] = 100; mem_b[6] = 7;
      check_frame("edge", 1, 65);
      checks++; if (bl1 !== -5'sd2 || bp1 !== 41'sd700) begin errors++; $display("FAIL edge_const: got %0d/%0d want -2/700", bl1, bp1); end
   endtask

   task automatic test_tie();
      clear_mem(); mem_a[8] = 10; mem_b[7] = 10; mem_b[9] = 10;
      check_frame("tie", 0, 64);
      checks++; if (bl0 !== -5'sd1 || bp0 !== 41'sd100) begin errors++; $display("FAIL tie_const: got %0d/%0d want -1/100", bl0, bp0); end
   endtask

   task automatic test_all_negative();
      clear_mem(); mem_a[8] = 100;
      for (int k = 0; k < BD; k++) mem_b[k] = -1;
      mem_b[10] = -3;
      check_frame("neg_signed", 0, 64);
      checks++; if (bl0 !== -5'sd2 || bp0 !== -41'sd100) begin errors++; $display("FAIL neg_signed_const: got %0d/%0d want -2/-100", bl0, bp0); end
      check_frame("neg_abs", 2, 64);
      checks++; if (bl2 !== 5'sd2 || bp2 !== -41'sd300) begin errors++; $display("FAIL neg_abs_const: got %0d/%0d want 2/-300", bl2, bp2); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < BD; i++) begin
            mem_a[i] = DW'(int'($urandom_range(0, 4095)) - 2048);
            mem_b[i] = DW'(int'($urandom_range(0, 4095)) - 2048);
         end
         check_frame("rand_lat1", 0, 64);
         check_frame("rand_lat2", 1, 65);
         check_frame("rand_abs", 2, 64);
      end
   endtask

   task automatic test_abort();
      int rvc, lat, elag;
      bit rise, bsy;
      longint epk;
      clear_mem(); mem_a[8] = 100; mem_b[9] = 50;
      check_frame("abort_pre", 0, 64);
      clear_mem(); mem_a[8] = 100; mem_b[6] = 50;
      @(negedge clk); full0 = 1'b1;
      rvc = 0;
      repeat (20) begin @(posedge clk); #1; if (rv0) rvc++; end
      @(negedge clk); full0 = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy0 !== 1'b0 || ready0 !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b ready %b want 0/0", busy0, ready0); end
      repeat (80) begin @(posedge clk); #1; if (rv0) rvc++; end
      checks++; if (rvc !== 0) begin errors++; $display("FAIL abort_no_strobe: got %0d strobes want 0", rvc); end
      checks++; if (bl0 !== 5'sd1 || bp0 !== 41'sd5000) begin errors++; $display("FAIL abort_keep: got %0d/%0d want 1/5000", bl0, bp0); end
      checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", ready0); end
      model(1'b0, elag, epk);
      run_frame(0, lat, rvc, rise, bsy);
      checks++; if (lat !== 64) begin errors++; $display("FAIL abort_rerun_latency: got %0d want 64", lat); end
      checks++; if (bl0 !== elag[LW-1:0] || longint'(bp0) !== epk) begin errors++; $display("FAIL abort_rerun_result: got %0d/%0d want %0d/%0d", bl0, bp0, elag, epk); end
   endtask

   task automatic test_reset_midrun();
      int rvc, lat;
      bit rise, bsy;
      clear_mem(); mem_a[8] = 100; mem_b[9] = 50;
      @(negedge clk); full0 = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk); rst_n = 1'b0; full0 = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy0 !== 1'b0 || ready0 !== 1'b0 || rv0 !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy %b ready %b rv %b want 0/0/0", busy0, ready0, rv0); end
      checks++; if (bl0 !== '0 || bp0 !== '0) begin errors++; $display("FAIL midrst_result: got %0d/%0d want 0/0", bl0, bp0); end
      checks++; if (ra0 !== '0 || rb0 !== '0) begin errors++; $display("FAIL midrst_addr: got %0d/%0d want 0/0", ra0, rb0); end
      @(negedge clk); rst_n = 1'b1;
      rvc = 0;
      repeat (80) begin @(posedge clk); #1; if (rv0 || ready0) rvc++; end
      checks++; if (rvc !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", rvc); end
      run_frame(0, lat, rvc, rise, bsy);
      checks++; if (lat !== 64 || rvc !== 1) begin errors++; $display("FAIL midrst_rerun: got latency %0d strobes %0d want 64/1", lat, rvc); end
      checks++; if (bl0 !== 5'sd1 || bp0 !== 41'sd5000) begin errors++; $display("FAIL midrst_rerun_result: got %0d/%0d want 1/5000", bl0, bp0); end
   endtask

   initial begin
      test_reset();
      test_delay_plus1();
      test_edge_lag_rdlat2();
      test_tie();
      test_all_negative();
      test_random();
      test_abort();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/xcorr_lag_search.md
Name: xcorr_lag_search

Overview:
- Parametrised cross-correlation lag estimator between two sample channels (A, B) held in frozen dual-read sample buffers.
- For every lag L in [-MAX_LAG, +MAX_LAG], computes S(L) = sum over n = MAX_LAG .. BUF_DEPTH-MAX_LAG-1 of a[n]*b[n+L].
- Reports the lag and value of the peak.
- Sits after the ADC capture buffers and feeds the direction/delay estimator.
- Successor to the fixed 500-sample, ±13 lag correlator: it adds generic sizes, configurable buffer read latency, a magnitude-peak mode, a result strobe, and clean abort.

Parameters:
- BUF_DEPTH, 500, samples per buffer.
- ADDR_W, 9, buffer address width (2^ADDR_W >= BUF_DEPTH).
- DATA_W, 12, signed sample width.
- MAX_LAG, 13, maximum lag magnitude (MAX_LAG < BUF_DEPTH/2).
- LAG_W, 5, signed lag width (must hold ±MAX_LAG).
- ACC_W, 41, signed accumulator width. An elaboration check enforces ACC_W >= 2*DATA_W + clog2(BUF_DEPTH-2*MAX_LAG).
- RD_LAT, 1, buffer read latency in cycles, from address to data (>= 0).
- PEAK_ABS, 0. 0: peak = max signed S. 1: peak = max |S|.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- full, in, 1, level: both buffers hold a complete frozen frame.
- rd_addr_a, out, ADDR_W, channel A read address (n).
- rd_addr_b, out, ADDR_W, channel B read address (n+L).
- data_a, in, DATA_W signed, A sample, RD_LAT cycles after rd_addr_a.
- data_b, in, DATA_W signed, B sample, RD_LAT cycles after rd_addr_b.
- busy, out, 1, run in progress.
- ready, out, 1, level: result valid for the current frame.
- result_valid, out, 1, one-cycle strobe when the result updates.
- best_lag, out, LAG_W signed, lag of the peak.
- best_peak, out, ACC_W signed, signed S at best_lag.

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low.
- Reset values: rd_addr_a/b = 0, busy = 0, ready = 0, result_valid = 0, best_lag = 0, best_peak = 0, state IDLE, pipeline tags cleared.
- N = BUF_DEPTH - 2*MAX_LAG terms per lag; NL = 2*MAX_LAG+1 lags.
- States:
  - IDLE: on an edge with full=1, go to RUN. busy=1 and ready=0 from the next cycle.
  - RUN: issue one address pair per cycle, with no bubbles between lags. n runs MAX_LAG..BUF_DEPTH-MAX_LAG-1, inner loop; L runs -MAX_LAG..+MAX_LAG, outer loop. Addresses are registered. After the last pair, go to DRAIN.
  - DRAIN: wait for the pipeline to empty, then go to DONE.
  - DONE: ready=1, busy=0; hold until full=0, then go to IDLE with ready=0. A new run requires full to go low then high.
- Pipeline:
  - Issue stage carries first/last tags.
  - Data arrives RD_LAT cycles later, then a product register, then the accumulator.
  - On a first tag, the accumulator loads the product; otherwise it adds the product.
  - On a last tag, the compare stage evaluates S(L).
- Peak rule:
  - S(-MAX_LAG) is taken unconditionally; there is no zero initial maximum.
  - A later lag replaces the best only if strictly greater (signed, or by |S| when PEAK_ABS=1), so ties keep the most negative lag.
  - best_lag and best_peak update only at run completion: result_valid pulses one cycle, coincident with ready rising.
  - Both hold until the next completed run.
- Latency: from the accepting edge to ready=1 is exactly NL*N + RD_LAT + 3 cycles.
- Arithmetic:
  - Products are full 2*DATA_W signed, sign-extended to ACC_W. There is no saturation; the width check guarantees no overflow.
  - |S| in PEAK_ABS mode uses an ACC_W+1 compare; best_peak always reports signed S.
- Abort: full=0 in RUN or DRAIN returns to IDLE at the next edge. The pipeline is flushed, busy=0, with no result_valid; best_lag and best_peak keep the previous result.
- rst_n=0 in any state applies the reset values at that edge, overriding all else.
- Addresses are always in range: 0 <= n+L <= BUF_DEPTH-1.

Decomposition:
- Package xcorr_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the lag/accumulator width check function;
  - the clog2-based term-count constant helper.
- One sub-module, xcorr_mac: a tagged, RD_LAT-aligned multiply-accumulate with first/last handling. It outputs (sum, sum_valid).
- Address sequencing and peak compare stay in the top.

Test Plan:
All scenarios use BUF_DEPTH=16, MAX_LAG=2, RD_LAT=1 (N=12, NL=5, latency 64) unless noted; unlisted samples are 0.
- Delay +1: a[8]=100, b[9]=50, raise full. Required: ready after exactly 64 cycles, result_valid 1 cycle, best_lag=+1, best_peak=5000.
- Edge lag with RD_LAT=2: a[8]=100, b[6]=7. Required: best_lag=-2, best_peak=700, latency 65.
- Tie: a[8]=10, b[7]=10, b[9]=10. Required: best_lag=-1, best_peak=100.
- All-negative: a[8]=100, b[k]=-1 for all k except b[10]=-3. PEAK_ABS=0 requires best_lag=-2, best_peak=-100. PEAK_ABS=1 requires best_lag=+2, best_peak=-300.
- Abort: after a completed run (lag +1), deassert full at cycle 20 of the next run. Required: no result_valid, ready=0, best_lag stays +1. Re-raising full completes in 64 cycles.
- Reset mid-run: rst_n=0 for one edge at cycle 30. Required: all outputs at reset values next cycle; no result_valid until a fresh full rise.
